buffer_resultado_ula: RTL and testbench

- Downstream stage of the 8-bit logic units (XOR/AND/OR).
- Captures each 8-bit result offered with a valid/ready handshake and derives status flags at capture time.
- Queues result and flags in a small FIFO, then presents them to the consumer (register file / display stage) with its own valid/ready handshake.
- Decouples ALU issue rate from consumer stalls.

---
 rtl/pkg_ula.sv | 22 ++
 rtl/fifo_resultado_ula.sv | 61 ++++++
 rtl/buffer_resultado_ula.sv | 84 ++++++++
 tb/tb_buffer_resultado_ula.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pkg_ula.sv
// Shared constants and entry layout for the logic-unit result path.
// Optional macro RESULTADO_PARIDADE_EN adds a stored parity flag to each entry.
package pkg_ula;

   localparam int LARGURA_ULA = 8;

   localparam int FLAG_ZERO = 0;
   localparam int FLAG_NEG  = 1;
   localparam int FLAG_PAR  = 2;

`ifdef RESULTADO_PARIDADE_EN
   localparam int NUM_FLAGS = 3;
`else
   localparam int NUM_FLAGS = 2;
`endif

   typedef struct packed {
      logic [LARGURA_ULA-1:0] dado;
      logic [NUM_FLAGS-1:0]   flags;
   } entrada_ula_t;

endpackage

// File: rtl/fifo_resultado_ula.sv
// Generic synchronous FIFO: storage array, read/write pointers, occupancy and flush.
// Storage is never cleared; only pointers and occupancy are reset.
module fifo_resultado_ula #(
   parameter int LARGURA_ENTRADA = 10,
   parameter int PROFUNDIDADE    = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             limpar,
   input  logic                             escrever,
   input  logic                             ler,
   input  logic [LARGURA_ENTRADA-1:0]       din,
   output logic [LARGURA_ENTRADA-1:0]       dout,
   output logic                             cheio,
   output logic                             vazio,
   output logic [$clog2(PROFUNDIDADE):0]    ocupacao
);

   localparam int PW = $clog2(PROFUNDIDADE);
   localparam logic [PW:0]   OCUP_MAX = (PW+1)'(PROFUNDIDADE);
   localparam logic [PW:0]   OCUP_UM  = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_UM   = PW'(1);

   logic [LARGURA_ENTRADA-1:0] mem [PROFUNDIDADE];
   logic [PW-1:0]              ptr_esc;
   logic [PW-1:0]              ptr_lei;
   logic                       push;
   logic                       pop;

   assign cheio = (ocupacao == OCUP_MAX);
   assign vazio = (ocupacao == '0);
   assign push  = escrever & ~cheio;
   assign pop   = ler & ~vazio;

   // Depth is a power of two, so pointers wrap naturally at PW bits.
   always_ff @(posedge clk) begin
      if (!rst_n || limpar) begin
         ptr_esc  <= '0;
         ptr_lei  <= '0;
         ocupacao <= '0;
      end else begin
         if (push)
            ptr_esc <= ptr_esc + PTR_UM;
         if (pop)
            ptr_lei <= ptr_lei + PTR_UM;
         case ({push, pop})
            2'b10:   ocupacao <= ocupacao + OCUP_UM;
            2'b01:   ocupacao <= ocupacao - OCUP_UM;
            default: ocupacao <= ocupacao;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && !limpar && push)
         mem[ptr_esc] <= din;
   end

   assign dout = mem[ptr_lei];

endmodule

// File: rtl/buffer_resultado_ula.sv
// Result buffer behind the XOR/AND/OR units: flags computed at capture, queued, gated when empty.
// Optional macro RESULTADO_PARIDADE_EN adds the out_paridade port and stored parity.
module buffer_resultado_ula
   import pkg_ula::*;
#(
   parameter int LARGURA      = LARGURA_ULA,
   parameter int PROFUNDIDADE = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          limpar,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [LARGURA-1:0]            in_dado,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [LARGURA-1:0]            out_dado,
   output logic                          out_zero,
   output logic                          out_neg,
`ifdef RESULTADO_PARIDADE_EN
   output logic                          out_paridade,
`endif
   output logic [$clog2(PROFUNDIDADE):0] ocupacao
);

   typedef struct packed {
      logic [LARGURA-1:0]   dado;
      logic [NUM_FLAGS-1:0] flags;
   } entrada_t;

   entrada_t entrada;
   entrada_t cabeca;
   logic     cheio;
   logic     vazio;

   // Flags are frozen at capture so the consumer sees exactly what the ALU produced.
   always_comb begin
      entrada                  = '0;
      entrada.dado             = in_dado;
      entrada.flags[FLAG_ZERO] = (in_dado == '0);
      entrada.flags[FLAG_NEG]  = in_dado[LARGURA-1];
`ifdef RESULTADO_PARIDADE_EN
      entrada.flags[FLAG_PAR]  = ^in_dado;
`endif
   end

   fifo_resultado_ula #(
      .LARGURA_ENTRADA ($bits(entrada_t)),
      .PROFUNDIDADE    (PROFUNDIDADE)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .limpar   (limpar),
      .escrever (in_valid),
      .ler      (out_ready),
      .din      (entrada),
      .dout     (cabeca),
      .cheio    (cheio),
      .vazio    (vazio),
      .ocupacao (ocupacao)
   );

   assign in_ready  = ~cheio;
   assign out_valid = ~vazio;

   // Stale storage is never exposed: everything reads zero while the queue is empty.
   always_comb begin
      out_dado = '0;
      out_zero = 1'b0;
      out_neg  = 1'b0;
`ifdef RESULTADO_PARIDADE_EN
      out_paridade = 1'b0;
`endif
      if (!vazio) begin
         out_dado = cabeca.dado;
         out_zero = cabeca.flags[FLAG_ZERO];
         out_neg  = cabeca.flags[FLAG_NEG];
`ifdef RESULTADO_PARIDADE_EN
         out_paridade = cabeca.flags[FLAG_PAR];
`endif
      end
   end

endmodule

// File: tb/tb_buffer_resultado_ula.sv
// Directed self-checking bench for buffer_resultado_ula (default depth 4, width 8).
// Compiles with or without RESULTADO_PARIDADE_EN.
module tb_buffer_resultado_ula;

   logic       clk;
   logic       rst_n;
   logic       limpar;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_dado;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_dado;
   logic       out_zero;
   logic       out_neg;
   logic [2:0] ocupacao;
`ifdef RESULTADO_PARIDADE_EN
   logic       out_paridade;
`endif

   int checks = 0;
   int errors = 0;

   buffer_resultado_ula #(
      .LARGURA      (8),
      .PROFUNDIDADE (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .limpar    (limpar),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_dado   (in_dado),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_dado  (out_dado),
      .out_zero  (out_zero),
      .out_neg   (out_neg),
`ifdef RESULTADO_PARIDADE_EN
      .out_paridade (out_paridade),
`endif
      .ocupacao  (ocupacao)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
      in_valid  = v;
      in_dado   = d;
      out_ready = r;
      tick();
   endtask

   task automatic checkOutput(input string tag, input logic ev, input logic [7:0] ed,
                              input logic ez, input logic en, input logic [2:0] eo,
                              input logic er, input logic ep);
      checks++;
      assert (out_valid === ev) else begin
         errors++;
         $error("[TB] FAIL %s out_valid observed %0b expected %0b", tag, out_valid, ev);
      end
      checks++;
      assert (out_dado === ed) else begin
         errors++;
         $error("[TB] FAIL %s out_dado observed %02h expected %02h", tag, out_dado, ed);
      end
      checks++;
      assert (out_zero === ez) else begin
         errors++;
         $error("[TB] FAIL %s out_zero observed %0b expected %0b", tag, out_zero, ez);
      end
      checks++;
      assert (out_neg === en) else begin
         errors++;
         $error("[TB] FAIL %s out_neg observed %0b expected %0b", tag, out_neg, en);
      end
      checks++;
      assert (ocupacao === eo) else begin
         errors++;
         $error("[TB] FAIL %s ocupacao observed %0d expected %0d", tag, ocupacao, eo);
      end
      checks++;
      assert (in_ready === er) else begin
         errors++;
         $error("[TB] FAIL %s in_ready observed %0b expected %0b", tag, in_ready, er);
      end
`ifdef RESULTADO_PARIDADE_EN
      checks++;
      assert (out_paridade === ep) else begin
         errors++;
         $error("[TB] FAIL %s out_paridade observed %0b expected %0b", tag, out_paridade, ep);
      end
`else
      if (ep === 1'bx) $display("[TB] note: parity unknown for %s", tag);
`endif
   endtask

   initial begin
      rst_n     = 1'b0;
      limpar    = 1'b0;
      in_valid  = 1'b0;
      in_dado   = 8'h00;
      out_ready = 1'b0;

      // Reset held two edges, then released
      tick();
      tick();
      checkOutput("reset_held", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
      rst_n = 1'b1;
      tick();
      checkOutput("idle", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);

      // Single push, visible next cycle
      applyStimulus(1'b1, 8'h5A, 1'b0);
      checkOutput("push_5a", 1'b1, 8'h5A, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("pop_5a", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);

      // Fill to full
      applyStimulus(1'b1, 8'h00, 1'b0);
      checkOutput("fill_00", 1'b1, 8'h00, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'h80, 1'b0);
      applyStimulus(1'b1, 8'hFF, 1'b0);
      checkOutput("fill_3", 1'b1, 8'h00, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'h01, 1'b0);
      checkOutput("full", 1'b1, 8'h00, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h33, 1'b0);
      checkOutput("full_ignore_33", 1'b1, 8'h00, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0);

      // Drain in order
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("drain_80", 1'b1, 8'h80, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("drain_ff", 1'b1, 8'hFF, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("drain_01", 1'b1, 8'h01, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("drain_empty", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);

      // Concurrent push/pop across pointer wrap
      for (int i = 0; i < 10; i++) begin
         logic [7:0] v;
         v = 8'h10 + 8'(i);
         applyStimulus(1'b1, v, 1'b1);
         checkOutput($sformatf("wrap_%02h", v), 1'b1, v, 1'b0, 1'b0, 3'd1, 1'b1, ^v);
      end
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("wrap_empty", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);

      // Flush with simultaneous push and pop
      applyStimulus(1'b1, 8'h21, 1'b0);
      applyStimulus(1'b1, 8'h22, 1'b0);
      applyStimulus(1'b1, 8'h23, 1'b0);
      checkOutput("pre_flush", 1'b1, 8'h21, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0);
      limpar = 1'b1;
      applyStimulus(1'b1, 8'hAA, 1'b1);
      limpar = 1'b0;
      checkOutput("flush", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("flush_no_aa", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);

      // Reset mid-operation
      applyStimulus(1'b1, 8'h44, 1'b0);
      applyStimulus(1'b1, 8'h55, 1'b0);
      checkOutput("pre_reset", 1'b1, 8'h44, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0);
      rst_n = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b0);
      rst_n = 1'b1;
      checkOutput("mid_reset", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'hC3, 1'b0);
      checkOutput("push_c3", 1'b1, 8'hC3, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("pop_c3", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("final_idle", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
